// File: rtl/serv_rf_dbg_arb.sv
// Debug-port arbiter for the SERV register-file RAM: turns 32-bit debug
// register reads/writes into width-bit RAM beats, always yielding to the CPU.
module serv_rf_dbg_arb #(
    parameter int width    = 8,
    parameter int csr_regs = 4,
    parameter int depth_l2 = $clog2((32 + csr_regs) * 32 / width)
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic [depth_l2-1:0] i_cpu_waddr,
    input  logic [width-1:0]    i_cpu_wdata,
    input  logic                i_cpu_wen,
    input  logic [depth_l2-1:0] i_cpu_raddr,
    input  logic                i_cpu_ren,
    output logic [width-1:0]    o_cpu_rdata,
    input  logic                i_halted,
    input  logic                i_dbg_req,
    input  logic                i_dbg_we,
    input  logic [5:0]          i_dbg_reg,
    input  logic [31:0]         i_dbg_wdata,
    output logic                o_dbg_ack,
    output logic                o_dbg_err,
    output logic [31:0]         o_dbg_rdata,
    output logic [depth_l2-1:0] o_ram_waddr,
    output logic [width-1:0]    o_ram_wdata,
    output logic                o_ram_wen,
    output logic [depth_l2-1:0] o_ram_raddr,
    output logic                o_ram_ren,
    input  logic [width-1:0]    i_ram_rdata
);

    localparam int beats  = 32 / width;
    localparam int beat_w = (beats > 1) ? $clog2(beats) : 1;
    localparam logic [6:0]        num_regs  = 7'(32 + csr_regs);
    localparam logic [beat_w-1:0] last_beat = beat_w'(beats - 1);

    typedef enum logic [2:0] {IDLE, RD, RD_LAST, WR, ACK} state_t;

    state_t              state;
    state_t              state_nxt;
    logic [beat_w-1:0]   beat;
    logic [5:0]          reg_q;
    logic [31:0]         wdata_q;
    logic [31:0]         rdata_q;
    logic                err_q;
    logic                rd_issued;
    logic                cpu_act;
    logic                dbg_go;
    logic                accept;
    logic                req_err;
    logic [depth_l2-1:0] dbg_addr;
    logic [width+31:0]   rd_shift;

    assign cpu_act  = i_cpu_wen | i_cpu_ren;
    assign dbg_go   = ((state == RD) || (state == WR)) && !cpu_act;
    assign accept   = (state == IDLE) && i_dbg_req;
    assign req_err  = !i_halted || ({1'b0, i_dbg_reg} >= num_regs);
    assign dbg_addr = depth_l2'(reg_q) * depth_l2'(beats) + depth_l2'(beat);
    // Beats arrive in ascending order, so shifting right lands beat 0 in the low bits.
    assign rd_shift = {i_ram_rdata, rdata_q};

    assign o_cpu_rdata = i_ram_rdata;
    assign o_dbg_ack   = (state == ACK);
    assign o_dbg_err   = err_q;
    assign o_dbg_rdata = rdata_q;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_dbg_req) begin
                    if (req_err || (i_dbg_reg == 6'd0)) state_nxt = ACK;
                    else if (i_dbg_we)                  state_nxt = WR;
                    else                                state_nxt = RD;
                end
            end
            RD:      if (dbg_go && (beat == last_beat)) state_nxt = RD_LAST;
            RD_LAST: state_nxt = ACK;
            WR:      if (dbg_go && (beat == last_beat)) state_nxt = ACK;
            ACK:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        o_ram_waddr = dbg_addr;
        o_ram_wdata = wdata_q[beat*width +: width];
        o_ram_raddr = dbg_addr;
        o_ram_wen   = 1'b0;
        o_ram_ren   = 1'b0;
        if (cpu_act) begin
            o_ram_waddr = i_cpu_waddr;
            o_ram_wdata = i_cpu_wdata;
            o_ram_wen   = i_cpu_wen;
            o_ram_raddr = i_cpu_raddr;
            o_ram_ren   = i_cpu_ren;
        end else if (dbg_go) begin
            o_ram_wen = (state == WR);
            o_ram_ren = (state == RD);
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state     <= IDLE;
            beat      <= '0;
            reg_q     <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            rd_issued <= 1'b0;
        end else begin
            state     <= state_nxt;
            rd_issued <= dbg_go && (state == RD);
            if (accept) begin
                reg_q   <= i_dbg_reg;
                wdata_q <= i_dbg_wdata;
                err_q   <= req_err;
                rdata_q <= '0;
                beat    <= '0;
            end else if (dbg_go) begin
                beat <= (beat == last_beat) ? '0 : beat + 1'b1;
            end
            if (rd_issued) rdata_q <= rd_shift[width +: 32];
        end
    end

endmodule

// File: tb/tb_serv_rf_dbg_arb.sv
// Bench for serv_rf_dbg_arb: a behavioural RAM plus a word-level register model
// predicting ack latency, err, rdata and the exact beat sequence of each request.
module tb_serv_rf_dbg_arb;

  localparam int W    = 8;
  localparam int CSR  = 4;
  localparam int DL2  = $clog2((32 + CSR) * 32 / W);
  localparam int N    = 32 / W;
  localparam int NREG = 32 + CSR;
  localparam int QW   = 1 + DL2 + W;

  logic           i_clk = 1'b0;
  logic           i_rst_n;
  logic [DL2-1:0] i_cpu_waddr, i_cpu_raddr;
  logic [W-1:0]   i_cpu_wdata, o_cpu_rdata;
  logic           i_cpu_wen, i_cpu_ren;
  logic           i_halted, i_dbg_req, i_dbg_we;
  logic [5:0]     i_dbg_reg;
  logic [31:0]    i_dbg_wdata, o_dbg_rdata;
  logic           o_dbg_ack, o_dbg_err;
  logic [DL2-1:0] o_ram_waddr, o_ram_raddr;
  logic [W-1:0]   o_ram_wdata, i_ram_rdata;
  logic           o_ram_wen, o_ram_ren;

  logic           pl_en;
  logic [DL2-1:0] pl_addr;
  logic [W-1:0]   pl_data;
  logic [W-1:0]   mem [0:(1<<DL2)-1];
  logic [31:0]    regs [0:NREG-1];

  int checks   = 0;
  int failures = 0;

  serv_rf_dbg_arb #(.width(W), .csr_regs(CSR)) dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_cpu_waddr(i_cpu_waddr), .i_cpu_wdata(i_cpu_wdata), .i_cpu_wen(i_cpu_wen),
    .i_cpu_raddr(i_cpu_raddr), .i_cpu_ren(i_cpu_ren), .o_cpu_rdata(o_cpu_rdata),
    .i_halted(i_halted), .i_dbg_req(i_dbg_req), .i_dbg_we(i_dbg_we),
    .i_dbg_reg(i_dbg_reg), .i_dbg_wdata(i_dbg_wdata),
    .o_dbg_ack(o_dbg_ack), .o_dbg_err(o_dbg_err), .o_dbg_rdata(o_dbg_rdata),
    .o_ram_waddr(o_ram_waddr), .o_ram_wdata(o_ram_wdata), .o_ram_wen(o_ram_wen),
    .o_ram_raddr(o_ram_raddr), .o_ram_ren(o_ram_ren), .i_ram_rdata(i_ram_rdata)
  );

  // clock / reset-free clock generation
  always #5 i_clk = ~i_clk;

  // RAM with one-cycle read latency and a preload port used during reset
  always @(posedge i_clk) begin
    if (pl_en) mem[pl_addr] <= pl_data;
    else if (o_ram_wen) mem[o_ram_waddr] <= o_ram_wdata;
    if (o_ram_ren) i_ram_rdata <= mem[o_ram_raddr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One debug transaction. CPU reads occupy cycles c_start .. c_start+c_len-1.
  task automatic txn(input logic we, input logic [5:0] r, input logic [31:0] wd,
                     input logic halted, input int c_start, input int c_len, input string tag);
    logic [QW-1:0] exp_q[$];
    logic [QW-1:0] obs;
    logic          exp_err;
    logic [31:0]   exp_rd;
    bit            ram_op;
    bit            got;
    int            exp_lat, lat, k, obs_n, exp_n;
    exp_err = !halted || (int'(r) >= NREG);
    ram_op  = !exp_err && (r != 6'd0);
    exp_rd  = (ram_op && !we) ? regs[r] : 32'd0;
    exp_lat = !ram_op ? 1 : ((we ? N + 1 : N + 2) + c_len);
    if (ram_op)
      for (int b = 0; b < N; b++)
        exp_q.push_back({we, DL2'(int'(r) * N + b), we ? wd[b*W +: W] : W'(0)});
    exp_n = exp_q.size();
    obs_n = 0;
    i_halted = halted; i_dbg_req = 1'b1; i_dbg_we = we; i_dbg_reg = r; i_dbg_wdata = wd;
    got = 0; lat = -1; k = 0;
    while (!got && k < 40) begin
      if (k > 0) i_dbg_req = 1'b0;
      if (k >= c_start && k < c_start + c_len) begin
        i_cpu_ren = 1'b1; i_cpu_raddr = DL2'($urandom);
      end else begin
        i_cpu_ren = 1'b0;
      end
      #1;
      if (i_cpu_ren) begin
        chk({tag, "_cpu_raddr"}, 32'(o_ram_raddr), 32'(i_cpu_raddr));
        chk({tag, "_cpu_ren"}, {31'd0, o_ram_ren}, 32'd1);
        chk({tag, "_cpu_rdata"}, 32'(o_cpu_rdata), 32'(i_ram_rdata));
      end else if (o_ram_wen || o_ram_ren) begin
        obs = {o_ram_wen, o_ram_wen ? o_ram_waddr : o_ram_raddr, o_ram_wen ? o_ram_wdata : W'(0)};
        obs_n++;
        if (exp_q.size() > 0) chk({tag, "_beat"}, 32'(obs), 32'(exp_q.pop_front()));
      end
      if (o_dbg_ack) begin
        got = 1; lat = k;
        chk({tag, "_err"}, {31'd0, o_dbg_err}, {31'd0, exp_err});
        chk({tag, "_rdata"}, o_dbg_rdata, exp_rd);
      end
      @(posedge i_clk); #1;
      k++;
    end
    i_cpu_ren = 1'b0;
    chk({tag, "_ack_seen"}, {31'd0, got}, 32'd1);
    chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    chk({tag, "_beat_count"}, 32'(obs_n), 32'(exp_n));
    #1;
    chk({tag, "_ack_pulse"}, {31'd0, o_dbg_ack}, 32'd0);
    chk({tag, "_rdata_hold"}, o_dbg_rdata, exp_rd);
    if (ram_op && we) regs[r] = wd;
  endtask

  initial begin
    logic [31:0] wd;
    i_rst_n = 1'b0; pl_en = 1'b0; pl_addr = '0; pl_data = '0;
    i_cpu_waddr = '0; i_cpu_wdata = '0; i_cpu_wen = 1'b0; i_cpu_raddr = '0; i_cpu_ren = 1'b0;
    i_halted = 1'b0; i_dbg_req = 1'b0; i_dbg_we = 1'b0; i_dbg_reg = '0; i_dbg_wdata = '0;

    // Preload the RAM during reset, one beat per cycle
    for (int r = 0; r < NREG; r++) regs[r] = $urandom;
    regs[5] = 32'hDEADBEEF;
    @(posedge i_clk); #1;
    chk("rst_ack", {31'd0, o_dbg_ack}, 32'd0);
    chk("rst_err", {31'd0, o_dbg_err}, 32'd0);
    chk("rst_rdata", o_dbg_rdata, 32'd0);
    chk("rst_ram_en", {30'd0, o_ram_wen, o_ram_ren}, 32'd0);
    for (int r = 0; r < NREG; r++)
      for (int b = 0; b < N; b++) begin
        pl_en = 1'b1; pl_addr = DL2'(r * N + b); pl_data = regs[r][b*W +: W];
        @(posedge i_clk); #1;
      end
    pl_en = 1'b0;
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;

    // Directed cases
    txn(1'b0, 6'd5,  32'h0,          1'b1, 0, 0, "read_x5");
    txn(1'b1, 6'd33, 32'h12345678,   1'b1, 0, 0, "write_csr33");
    txn(1'b0, 6'd33, 32'h0,          1'b1, 0, 0, "readback_csr33");
    txn(1'b0, 6'd5,  32'h0,          1'b1, 2, 2, "contention_x5");
    txn(1'b0, 6'd36, 32'h0,          1'b1, 0, 0, "err_reg36");
    txn(1'b0, 6'd3,  32'h0,          1'b0, 0, 0, "err_not_halted");
    txn(1'b1, 6'd0,  32'hFFFFFFFF,   1'b1, 0, 0, "write_x0");
    txn(1'b0, 6'd0,  32'h0,          1'b1, 0, 0, "read_x0");
    txn(1'b1, 6'd31, 32'hA5A5_0F0F,  1'b1, 1, 3, "write_contention");
    txn(1'b0, 6'd31, 32'h0,          1'b1, 0, 0, "readback_x31");

    // Reset in the middle of a write: beats 0 and 1 land, beat 2 is cut off
    txn(1'b0, 6'd9, 32'h0, 1'b1, 0, 0, "pre_reset_read");
    wd = 32'hCAFE_1234;
    i_halted = 1'b1; i_dbg_req = 1'b1; i_dbg_we = 1'b1; i_dbg_reg = 6'd7; i_dbg_wdata = wd;
    @(posedge i_clk); #1;
    i_dbg_req = 1'b0;
    @(posedge i_clk); #1;
    @(posedge i_clk); #1;
    chk("mid_wr_beat2_addr", 32'(o_ram_waddr), 32'(7 * N + 2));
    chk("mid_wr_beat2_wen", {31'd0, o_ram_wen}, 32'd1);
    i_rst_n = 1'b0;
    #1;
    chk("mid_rst_wen", {31'd0, o_ram_wen}, 32'd0);
    chk("mid_rst_err", {31'd0, o_dbg_err}, 32'd0);
    chk("mid_rst_rdata", o_dbg_rdata, 32'd0);
    for (int i = 0; i < 3; i++) begin
      @(posedge i_clk); #1;
      chk("mid_rst_no_ack", {31'd0, o_dbg_ack}, 32'd0);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    regs[7] = {regs[7][31:16], wd[15:0]};
    txn(1'b0, 6'd7, 32'h0, 1'b1, 0, 0, "after_reset_read_x7");

    // Randomized traffic against the register model
    for (int t = 0; t < 40; t++) begin
      logic        rwe, rh;
      logic [5:0]  rr;
      int          cs, cl;
      rwe = 1'($urandom_range(1, 0));
      rr  = 6'($urandom_range(NREG + 3, 0));
      rh  = ($urandom_range(9, 0) != 0);
      cs  = $urandom_range(N, 1);
      cl  = $urandom_range(2, 0);
      txn(rwe, rr, $urandom, rh, cs, cl, "random");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
